// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and width helper for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {S_IDLE, S_EXT_BURST} arb_state_e;
  typedef enum logic {PORT_CPU = 1'b0, PORT_EXT = 1'b1} port_id_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, external requester and datamem signals around the arbiter
interface dmem_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req;
  logic          ext_lock;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating wait counter that flags when EXT has waited LIMIT cycles
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign sat = cnt == W'(LIMIT);
  // count waiting cycles, holding at LIMIT until EXT is served or withdraws
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port datamem between CPU and EXT; DMEM_ARB_PERF_EN adds perf counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_ext_beats
`endif
);
  localparam int BW = clog2(MAX_BURST + 1);
  arb_state_e state;
  logic [BW-1:0] beatCnt;
  logic rdPend;
  port_id_e rdPort;
  logic starveSat, burstCont, extGnt, cpuGnt, starveInc;
  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) starveCtr (
    .clk  (clk),
    .reset(reset),
    .inc  (starveInc),
    .clr  (!starveInc),
    .sat  (starveSat)
  );
  // grant: burst continuation beats the CPU, otherwise starved EXT, then CPU, then EXT
  always_comb begin
    burstCont = bus.ext_req && bus.ext_lock && (beatCnt < BW'(MAX_BURST));
    extGnt = (state == S_EXT_BURST) ? burstCont : bus.ext_req && (starveSat || !bus.cpu_req);
    cpuGnt = bus.cpu_req && !extGnt;
    starveInc = bus.ext_req && !extGnt;
  end
  assign bus.cpu_stall  = bus.cpu_req && !cpuGnt;
  assign bus.ext_gnt    = extGnt;
  assign bus.mem_we     = extGnt ? bus.ext_we : cpuGnt && bus.cpu_we;
  assign bus.mem_re     = extGnt ? !bus.ext_we : cpuGnt && !bus.cpu_we;
  assign bus.mem_addr   = extGnt ? bus.ext_addr : cpuGnt ? bus.cpu_addr : '0;
  assign bus.mem_wdata  = extGnt ? bus.ext_wdata : cpuGnt ? bus.cpu_wdata : '0;
  assign bus.cpu_rvalid = rdPend && rdPort == PORT_CPU;
  assign bus.ext_rvalid = rdPend && rdPort == PORT_EXT;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rdata : '0;
  // burst FSM with beat count, plus the read tag steering next-cycle data
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      beatCnt <= '0;
      rdPend  <= 1'b0;
      rdPort  <= PORT_CPU;
    end else begin
      state   <= (extGnt && bus.ext_lock) ? S_EXT_BURST : S_IDLE;
      beatCnt <= (extGnt && bus.ext_lock) ? beatCnt + 1'b1 : '0;
      rdPend  <= bus.mem_re;
      rdPort  <= extGnt ? PORT_EXT : PORT_CPU;
    end
  end
`ifdef DMEM_ARB_PERF_EN
  // free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_ext_beats <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(bus.cpu_stall);
      perf_ext_beats <= perf_ext_beats + 32'(extGnt);
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a transaction-level arbitration model
module tb_dmem_arbiter;
  localparam int MAX_BURST = 4;
  localparam int STARVE_LIMIT = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_arbiter_if #(.AW(16), .DW(16)) bus ();
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perfStall, perfBeats;
`endif
  dmem_arbiter #(.MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt(perfStall),
    .perf_ext_beats(perfBeats)
`endif
  );
  logic [15:0] ram[256];
  logic [15:0] refMem[256];
  int tests = 0, fails = 0;
  int mRun, mWait;
  bit mRdPend, mRdExt, eCpuGnt, eExtGnt;
  logic [15:0] mRdData;
  logic [31:0] mStall, mBeats;
  always #5 clk = ~clk;
  // synchronous single-port datamem model
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end
  // who wins this cycle, straight from the priority rules
  function automatic void predict();
    bit inBurst;
    inBurst = mRun > 0;
    eExtGnt = 0;
    eCpuGnt = 0;
    if (inBurst && mRun < MAX_BURST && bus.ext_req && bus.ext_lock) eExtGnt = 1;
    else if (!inBurst && bus.ext_req && mWait == STARVE_LIMIT) eExtGnt = 1;
    else if (bus.cpu_req) eCpuGnt = 1;
    else if (!inBurst && bus.ext_req) eExtGnt = 1;
  endfunction
  function automatic void commit();
    logic [7:0] a;
    a = eExtGnt ? bus.ext_addr[7:0] : bus.cpu_addr[7:0];
    mRdPend = (eCpuGnt && !bus.cpu_we) || (eExtGnt && !bus.ext_we);
    mRdExt = eExtGnt;
    mRdData = refMem[a];
    if ((eCpuGnt && bus.cpu_we) || (eExtGnt && bus.ext_we)) refMem[a] = eExtGnt ? bus.ext_wdata : bus.cpu_wdata;
    mStall += 32'(bus.cpu_req && !eCpuGnt);
    mBeats += 32'(eExtGnt);
    mRun = (eExtGnt && bus.ext_lock) ? mRun + 1 : 0;
    mWait = (bus.ext_req && !eExtGnt) ? ((mWait < STARVE_LIMIT) ? mWait + 1 : mWait) : 0;
  endfunction
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mRun = 0;
      mWait = 0;
      mRdPend = 0;
      mStall = 0;
      mBeats = 0;
    end else commit();
    #1;
  endtask
  task automatic drive(input bit cr, cw, input logic [15:0] ca, cd, input bit er, el, ew, input logic [15:0] ea, ed);
    bus.cpu_req = cr;
    bus.cpu_we = cw;
    bus.cpu_addr = ca;
    bus.cpu_wdata = cd;
    bus.ext_req = er;
    bus.ext_lock = el;
    bus.ext_we = ew;
    bus.ext_addr = ea;
    bus.ext_wdata = ed;
    predict();
    #3;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0005, 16'h0);
    tests++;
    if ({bus.ext_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.ext_rvalid} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ext_only got gnt/stall/crv/erv=%b want 1000", {bus.ext_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.ext_rvalid});
    end
    tick();
    drive(1, 1, 16'h0030, 16'hbeef, 0, 0, 0, 16'h0, 16'h0);
    tests++;
    if ({bus.cpu_stall, bus.mem_we, bus.mem_re, bus.ext_rvalid} !== 4'b0101) begin
      fails++;
      $display("FAIL reset_cpu_store got stall/we/re/erv=%b want 0101", {bus.cpu_stall, bus.mem_we, bus.mem_re, bus.ext_rvalid});
    end
    tick();
  endtask
  task automatic test_cpu_load();
    do_reset();
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    tests++;
    if ({bus.cpu_stall, bus.mem_re, bus.mem_addr} !== {1'b0, 1'b1, 16'h0010}) begin
      fails++;
      $display("FAIL cpu_load_issue got stall=%b re=%b addr=%h want 0 1 0010", bus.cpu_stall, bus.mem_re, bus.mem_addr);
    end
    tick();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    tests++;
    if ({bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata} !== {2'b10, 16'h1234}) begin
      fails++;
      $display("FAIL cpu_load_data got rv=%b%b rdata=%h want 10 1234", bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata);
    end
    tick();
  endtask
  task automatic test_starve();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 16'h0011, 16'h0, 1, 0, 0, 16'h0022, 16'h0);
      tests++;
      if ({bus.ext_gnt, bus.cpu_stall} !== {i == 9, i == 9}) begin
        fails++;
        $display("FAIL starve_cycle%0d got gnt=%b stall=%b want %b %b", i, bus.ext_gnt, bus.cpu_stall, i == 9, i == 9);
      end
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    tests++;
    if ({perfStall, perfBeats} !== {32'd1, 32'd1}) begin
      fails++;
      $display("FAIL perf_counts got stall=%0d beats=%0d want 1 1", perfStall, perfBeats);
    end
`endif
  endtask
  task automatic test_burst();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      drive(i >= 2 && i != 7, 0, 16'h0020, 16'h0, 1, 1, 1, 16'(16'h0040 + i), 16'(i));
      tests++;
      if ({bus.ext_gnt, bus.cpu_stall} !== {i <= 4 || i == 7, i >= 2 && i <= 4}) begin
        fails++;
        $display("FAIL burst_cycle%0d got gnt=%b stall=%b want %b %b", i, bus.ext_gnt, bus.cpu_stall, i <= 4 || i == 7, i >= 2 && i <= 4);
      end
      tick();
    end
  endtask
  task automatic test_alternate();
    logic [15:0] a;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      a = 16'($urandom_range(0, 31));
      if (i == 10) drive(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      else if (i % 2 == 0) drive(1, 0, a, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      else drive(0, 0, 16'h0, 16'h0, 1, 0, 0, a, 16'h0);
      tests++;
      if ({bus.cpu_rvalid, bus.ext_rvalid} !== {mRdPend && !mRdExt, mRdPend && mRdExt}) begin
        fails++;
        $display("FAIL alt_rvalid%0d got %b%b want %b%b", i, bus.cpu_rvalid, bus.ext_rvalid, mRdPend && !mRdExt, mRdPend && mRdExt);
      end
      tests++;
      if ((bus.cpu_rvalid ? bus.cpu_rdata : bus.ext_rdata) !== (mRdPend ? mRdData : 16'h0)) begin
        fails++;
        $display("FAIL alt_rdata%0d got %h want %h", i, bus.cpu_rvalid ? bus.cpu_rdata : bus.ext_rdata, mRdPend ? mRdData : 16'h0);
      end
      tick();
    end
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    drive(0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0003, 16'h0);
    tick();
    drive(0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0004, 16'h0);
    tests++;
    if (bus.ext_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midburst_beat2 got gnt=%b want 1", bus.ext_gnt);
    end
    tick();
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0005, 16'h0);
    tests++;
    if ({bus.ext_rvalid, bus.ext_rdata} !== {1'b1, refMem[4]}) begin
      fails++;
      $display("FAIL midburst_rdata got rv=%b rdata=%h want 1 %h", bus.ext_rvalid, bus.ext_rdata, refMem[4]);
    end
    tick();
    reset = 1'b0;
    drive(1, 0, 16'h0006, 16'h0, 1, 1, 0, 16'h0007, 16'h0);
    tests++;
    if ({bus.ext_rvalid, bus.cpu_rvalid, bus.ext_gnt, bus.cpu_stall} !== 4'b0000) begin
      fails++;
      $display("FAIL midburst_after_reset got erv/crv/gnt/stall=%b want 0000", {bus.ext_rvalid, bus.cpu_rvalid, bus.ext_gnt, bus.cpu_stall});
    end
    tick();
  endtask
  task automatic test_random();
    bit er, el, ew, expWe, expRe, cRv, eRv;
    logic [15:0] ea, ed;
    er = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!er || eExtGnt) begin
        er = $urandom_range(0, 2) != 0;
        el = $urandom_range(0, 3) != 0;
        ew = 1'($urandom_range(0, 1));
        ea = 16'($urandom_range(0, 31));
        ed = 16'($urandom);
      end
      drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom), er, el, ew, ea, ed);
      expWe = (eCpuGnt && bus.cpu_we) || (eExtGnt && bus.ext_we);
      expRe = (eCpuGnt && !bus.cpu_we) || (eExtGnt && !bus.ext_we);
      tests++;
      if ({bus.cpu_stall, bus.ext_gnt, bus.mem_we, bus.mem_re} !== {bus.cpu_req && !eCpuGnt, eExtGnt, expWe, expRe}) begin
        fails++;
        $display("FAIL rand_grant%0d got stall/gnt/we/re=%b want %b", i, {bus.cpu_stall, bus.ext_gnt, bus.mem_we, bus.mem_re}, {bus.cpu_req && !eCpuGnt, eExtGnt, expWe, expRe});
      end
      if (eCpuGnt || eExtGnt) begin
        tests++;
        if ({bus.mem_addr, bus.mem_wdata} !== (eExtGnt ? {bus.ext_addr, bus.ext_wdata} : {bus.cpu_addr, bus.cpu_wdata})) begin
          fails++;
          $display("FAIL rand_membus%0d got addr=%h wdata=%h", i, bus.mem_addr, bus.mem_wdata);
        end
      end
      cRv = mRdPend && !mRdExt;
      eRv = mRdPend && mRdExt;
      tests++;
      if ({bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata} !== {cRv, eRv, cRv ? mRdData : 16'h0, eRv ? mRdData : 16'h0}) begin
        fails++;
        $display("FAIL rand_read%0d got rv=%b%b c=%h e=%h want rv=%b%b data=%h", i, bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata, cRv, eRv, mRdData);
      end
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    drive(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    tests++;
    if ({perfStall, perfBeats} !== {mStall, mBeats}) begin
      fails++;
      $display("FAIL rand_perf got stall=%0d beats=%0d want %0d %0d", perfStall, perfBeats, mStall, mBeats);
    end
`endif
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'(i * 16'h0137 + 16'h5a5a);
      refMem[i] = ram[i];
    end
    ram[16] = 16'h1234;
    refMem[16] = 16'h1234;
    test_reset();
    test_cpu_load();
    test_starve();
    test_burst();
    test_alternate();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
